// File: rtl/au_int_exp2_seq_pkg.sv
// Shared constants and helpers for the au_int_exp2_seq power-of-two scaler.
package au_int_exp2_seq_pkg;

    // Controller states: wait for operands, step shifter stages, hold result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } exp2_state_e;

    // Width needed to hold a shift amount for an x-bit word, never below 1.
    function automatic int au_clog2_min1(input int x);
        int r;
        r = $clog2(x);
        if (r < 1) begin
            return 1;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/au_int_exp2_seq.sv
// Sequential z = m * 2^e scaler. Each SHIFT cycle applies one log-shifter
// stage (shift by 2^k when exponent bit k is set) and accumulates overflow.
module au_int_exp2_seq
    import au_int_exp2_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int EW = au_clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] m,
    input  logic [EW-1:0]    e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             ovf
);

    localparam int            K_LAST_INT = EW - 1;
    localparam int            K_ONE_INT  = 1;
    localparam logic [EW-1:0] K_LAST     = K_LAST_INT[EW-1:0];
    localparam logic [EW-1:0] K_ONE      = K_ONE_INT[EW-1:0];

    exp2_state_e      state_r;
    logic [EW-1:0]    k_r;
    logic [EW-1:0]    exp_r;
    logic [WIDTH-1:0] acc_r;
    logic             ovf_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] stage_acc_s;
    logic             stage_lost_s;

    // Ready only while idle and not being reset, so nothing is taken during reset.
    assign in_ready  = (state_r == ST_IDLE) && !rst;
    assign out_valid = out_valid_r;
    assign z         = acc_r;
    assign ovf       = ovf_r;

    // Stage mux: shift acc by 2^k and report whether any set bit falls off the top.
    always_comb begin
        stage_acc_s  = acc_r;
        stage_lost_s = 1'b0;
        for (int i = 0; i < EW; i++) begin
            if (k_r == i[EW-1:0]) begin
                if ((32'd1 << i) >= WIDTH) begin
                    stage_acc_s  = '0;
                    stage_lost_s = |acc_r;
                end else begin
                    stage_acc_s  = acc_r << (32'd1 << i);
                    stage_lost_s = |(acc_r >> (WIDTH - (32'd1 << i)));
                end
            end else begin
                stage_acc_s  = stage_acc_s;
                stage_lost_s = stage_lost_s;
            end
        end
    end

    // Controller: load operands, step every exponent bit, then hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            k_r         <= '0;
            exp_r       <= '0;
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_r   <= m;
                        exp_r   <= e;
                        k_r     <= '0;
                        ovf_r   <= 1'b0;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (exp_r[k_r]) begin
                        acc_r <= stage_acc_s;
                        ovf_r <= ovf_r | stage_lost_s;
                    end else begin
                        acc_r <= acc_r;
                        ovf_r <= ovf_r;
                    end
                    if (k_r == K_LAST) begin
                        k_r         <= '0;
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        k_r <= k_r + K_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    k_r         <= '0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_au_int_exp2_seq.sv
// Scoreboard bench for au_int_exp2_seq: WIDTH=8 and WIDTH=6 instances checked
// against a plain (m << e) arithmetic reference.
module tb_au_int_exp2_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // WIDTH = 8 instance signals
    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] m8 = 8'd0;
    logic [2:0] e8 = 3'd0;
    logic       out_valid8;
    logic       out_ready8 = 1'b1;
    logic [7:0] z8;
    logic       ovf8;

    // WIDTH = 6 instance signals
    logic       in_valid6 = 1'b0;
    logic       in_ready6;
    logic [5:0] m6 = 6'd0;
    logic [2:0] e6 = 3'd0;
    logic       out_valid6;
    logic       out_ready6 = 1'b1;
    logic [5:0] z6;
    logic       ovf6;

    int checks = 0;
    int errors = 0;
    logic rand_ready = 1'b0;

    logic [8:0] exp_q8[$];
    logic [6:0] exp_q6[$];

    au_int_exp2_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .m(m8), .e(e8), .out_valid(out_valid8), .out_ready(out_ready8),
        .z(z8), .ovf(ovf8)
    );

    au_int_exp2_seq #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
        .m(m6), .e(e6), .out_valid(out_valid6), .out_ready(out_ready6),
        .z(z6), .ovf(ovf6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: full-precision product, low W bits are z, anything above is overflow.
    function automatic logic [8:0] ref8(input logic [7:0] mm, input int ee);
        longint full;
        full = longint'(mm) * (longint'(1) << ee);
        return {full >= 256, full[7:0]};
    endfunction

    function automatic logic [6:0] ref6(input logic [5:0] mm, input int ee);
        longint full;
        full = longint'(mm) * (longint'(1) << ee);
        return {full >= 64, full[5:0]};
    endfunction

    // Monitors: pop and compare at each output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (exp_q8.size() == 0) begin
                chk("unexpected_out8", {55'd0, ovf8, z8}, 64'hDEAD);
            end else begin
                chk("out8", {55'd0, ovf8, z8}, {55'd0, exp_q8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid6 && out_ready6) begin
            if (exp_q6.size() == 0) begin
                chk("unexpected_out6", {57'd0, ovf6, z6}, 64'hDEAD);
            end else begin
                chk("out6", {57'd0, ovf6, z6}, {57'd0, exp_q6.pop_front()});
            end
        end
    end

    // Random consumer backpressure during the sweep.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready8 = ($urandom_range(0, 3) != 0);
    end

    task automatic send8(input logic [7:0] mm, input logic [2:0] ee, input bit push);
        int guard = 0;
        while (!in_ready8 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready8) begin
            chk("send8_timeout", 64'd0, 64'd1);
        end else begin
            m8 = mm; e8 = ee; in_valid8 = 1'b1;
            if (push) exp_q8.push_back(ref8(mm, int'(ee)));
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            m8 = $urandom; e8 = $urandom;
        end
    endtask

    task automatic send6(input logic [5:0] mm, input logic [2:0] ee);
        int guard = 0;
        while (!in_ready6 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready6) begin
            chk("send6_timeout", 64'd0, 64'd1);
        end else begin
            m6 = mm; e6 = ee; in_valid6 = 1'b1;
            exp_q6.push_back(ref6(mm, int'(ee)));
            @(posedge clk); #1;
            in_valid6 = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((exp_q8.size() != 0 || exp_q6.size() != 0) && guard < 500) begin
            @(posedge clk); #1; guard++;
        end
        chk(name, 64'(exp_q8.size() + exp_q6.size()), 64'd0);
    endtask

    initial begin
        logic [7:0] hz;
        logic       hovf;
        int guard;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", 64'(z8), 64'd0);
        chk("rst_ovf", 64'(ovf8), 64'd0);
        chk("rst_out_valid", 64'(out_valid8), 64'd0);
        chk("rst_in_ready", 64'(in_ready8), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready8), 64'd1);

        // Latency: accept at edge 0, result visible after edge 3
        send8(8'h01, 3'd5, 1'b1);
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk); #1;
            chk($sformatf("latency_edge%0d", j), 64'(out_valid8), (j == 3) ? 64'd1 : 64'd0);
        end
        drain("drain_first");

        // Directed patterns and boundaries
        send8(8'h16, 3'd2, 1'b1);
        send8(8'h16, 3'd3, 1'b1);
        send8(8'h16, 3'd4, 1'b1);
        send8(8'hFF, 3'd0, 1'b1);
        send8(8'h00, 3'd7, 1'b1);
        send8(8'h80, 3'd1, 1'b1);
        send8(8'hFF, 3'd7, 1'b1);
        drain("drain_directed");

        // Backpressure: hold result in DONE with a competing in_valid
        out_ready8 = 1'b0;
        send8(8'h2B, 3'd3, 1'b1);
        guard = 0;
        while (!out_valid8 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        chk("bp_valid_rise", 64'(out_valid8), 64'd1);
        hz = z8; hovf = ovf8;
        in_valid8 = 1'b1; m8 = 8'h11; e8 = 3'd1;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            chk("bp_z_stable", 64'(z8), 64'(hz));
            chk("bp_ovf_stable", 64'(ovf8), 64'(hovf));
            chk("bp_in_ready_low", 64'(in_ready8), 64'd0);
            chk("bp_valid_held", 64'(out_valid8), 64'd1);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", 64'(out_valid8), 64'd0);
        chk("bp_in_ready_back", 64'(in_ready8), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_no_extra", 64'(out_valid8), 64'd0);
        drain("drain_bp");

        // Reset after one SHIFT edge aborts the operation
        send8(8'h33, 3'd1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_z", 64'(z8), 64'd0);
        chk("abort_ovf", 64'(ovf8), 64'd0);
        chk("abort_valid", 64'(out_valid8), 64'd0);
        chk("abort_in_ready", 64'(in_ready8), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready_back", 64'(in_ready8), 64'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 64'(out_valid8), 64'd0);
        end
        send8(8'h16, 3'd3, 1'b1);
        drain("drain_after_abort");

        // Random sweep with random consumer stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send8($urandom, $urandom, 1'b1);
        end
        drain("drain_rand8");
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready8 = 1'b1;

        // WIDTH = 6: exponents past the word length
        send6(6'h01, 3'd7);
        send6(6'h01, 3'd6);
        send6(6'h00, 3'd7);
        send6(6'h3F, 3'd5);
        for (int n = 0; n < 30; n++) begin
            send6($urandom, $urandom);
        end
        drain("drain_rand6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1);
    end

endmodule

// File: doc/au_int_exp2_seq.md
# au_int_exp2_seq

Sequential integer power-of-two scaler: computes z = m · 2^e, truncated to WIDTH bits, and flags overflow. It is the inverse of the integer log2 / leading-one encoder: with m = 1, floor(log2(z)) = e whenever ovf = 0. The block sits in the arithmetic-unit library next to the log2 and encode blocks. It processes one exponent bit per cycle, one log-shifter stage per cycle, behind valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: word length of m and z (>= 1).
- EW (localparam), max(ceil(log2(WIDTH)), 1): exponent width; not overridable.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  m/e presented.
- in_ready  output  1  block can accept; equals (state == IDLE) && !rst.
- m  input  WIDTH  unsigned mantissa.
- e  input  EW  unsigned shift exponent.
- out_valid  output  1  z/ovf valid.
- out_ready  input  1  consumer accepts result.
- z  output  WIDTH  registered result, (m << e) mod 2^WIDTH.
- ovf  output  1  registered flag; 1 iff any set bit of m was shifted out (m << e >= 2^WIDTH).

## Operation
- States are IDLE, SHIFT and DONE, with counter k in [0, EW-1], accumulator acc (drives z), and registers exp and ovf.
- IDLE: when in_valid && in_ready at an edge, load acc = m, exp = e, k = 0, ovf = 0, and go to SHIFT. m and e are sampled only at this edge.
- SHIFT, each edge: with s = 2^k:
  - If exp[k] = 1: acc <= acc << s, and ovf <= ovf | (acc[WIDTH-1 -: min(s,WIDTH)] != 0).
  - If s >= WIDTH and exp[k] = 1: acc becomes 0, and ovf |= (acc != 0).
  - If exp[k] = 0: acc and ovf hold.
  - k <= k+1. The edge with k = EW-1 moves to DONE instead.
- DONE: out_valid = 1, and z/ovf are held stable. On an edge with out_ready = 1, return to IDLE and drop out_valid.
- Exponents e >= WIDTH are legal (non-power-of-two WIDTH). The result is 0, and ovf = (m != 0).
- m = 0 always gives z = 0 and ovf = 0.
- The SHIFT phase has no early exit; all EW stages are always stepped.

## Timing
- Reset values (edge with rst = 1): state IDLE, z = 0, ovf = 0, out_valid = 0, k = 0. in_ready is 0 while rst is high and 1 on the first cycle after deassertion.
- Reset mid-SHIFT or in DONE aborts the operation. No result is emitted, and the in-flight operand is discarded.
- Latency: with acceptance at edge 0, out_valid rises after edge EW (EW = 3 → after edge 3).
- out_valid stays high indefinitely until out_ready is seen. z and ovf do not change while out_valid = 1.
- in_ready is low in SHIFT and DONE. New input is accepted no earlier than the first IDLE cycle after the out_ready handshake.
- Peak throughput is one op per EW+2 cycles.
- in_valid asserted during SHIFT/DONE is ignored, not queued.
- out_ready in IDLE/SHIFT has no effect.
- WIDTH = 1: EW = 1, a single SHIFT cycle; e = 1 gives z = 0, ovf = m.

## Structure
- The max(ceil(log2(x)), 1) width function belongs in the shared AU constant-function include, used by both this block and the log2 encoder.
- State encodings (IDLE, SHIFT, DONE) are localparams in that include.
- No sub-module. The per-stage shift is an inline combinational mux selected by k.

## Test plan
- WIDTH = 8, m = 0x01, e = 5 → z = 0x20, ovf = 0, out_valid after edge 3; log2 of z returns 5.
- m = 0x16: e = 2 → z = 0x58, ovf = 0; e = 3 → z = 0xB0, ovf = 0; e = 4 → z = 0x60, ovf = 1.
- Boundaries: m = 0xFF, e = 0 → z = 0xFF, ovf = 0. m = 0x00, e = 7 → z = 0x00, ovf = 0. m = 0x80, e = 1 → z = 0x00, ovf = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → z/ovf stable, in_ready = 0, a concurrent in_valid is not accepted. Raise out_ready → IDLE next edge, in_ready = 1.
- Reset after 1 SHIFT edge → next edge all outputs reset, no out_valid pulse. A fresh op afterwards produces the correct result.
- WIDTH = 6 (EW = 3), m = 0x01, e = 7 → z = 0, ovf = 1. Then random sweep of m and e, compared against a reference (m << e) model, including back-to-back ops.
